serial_add_ctrl: RTL and testbench

//  Sequencer that adds two WIDTH-bit words bit-serially through one shared

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_ha.sv | 12 +
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers (add now, subtract/compare later).
package serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PH0  = 2'd1;
    localparam logic [1:0] ST_PH1  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bit-index register width; never narrower than one bit so WIDTH=1 still has an idx flop.
    function automatic int idx_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_ha.sv
// Single-bit half adder; the one shared arithmetic cell of the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: two cycles per bit through one half adder,
// valid/ready operand port in, valid/ready result port out.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int IW = idx_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic ha_a, ha_b, ha_s, ha_c;

    half_adder ha_u0 (
        .a (ha_a),
        .b (ha_b),
        .s (ha_s),
        .c (ha_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        ha_a    = 1'b0;
        ha_b    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    sum_d   = '0;
                    state_d = ST_PH0;
                end
            end
            ST_PH0: begin
                ha_a    = opa_q[idx_q];
                ha_b    = opb_q[idx_q];
                s1_d    = ha_s;
                c1_d    = ha_c;
                state_d = ST_PH1;
            end
            ST_PH1: begin
                // Second half of a full add: fold the running carry into the partial sum.
                ha_a         = s1_q;
                ha_b         = cin_q;
                sum_d[idx_q] = ha_s;
                cin_d        = c1_q | ha_c;
                if (idx_q == IW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_PH0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = out_valid & cin_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=16 and WIDTH=1 against an a+b reference.
module tb_serial_add_ctrl;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1, co16;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b1, co1;
    logic [0:0]  a1 = '0, b1 = '0, s1;

    serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .carry_out(co16)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1)
    );

    exp_t q16[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   n_push16 = 0, n_got16 = 0, n_push1 = 0, n_got1 = 0;
    int   tmo = 0;
    logic chk_rst = 1'b0, done_req = 1'b0, done_ack = 1'b0, rnd_done = 1'b0;
    logic hs16 = 1'b0, pv16 = 1'b0, hs1 = 1'b0, pv1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output observation happens here on the falling edge.
    always @(negedge clk) begin
        if (chk_rst) begin
            chk("rst_in_ready", 32'(ir16), 1);
            chk("rst_out_valid", 32'(ov16), 0);
            chk("rst_sum", 32'(s16), 0);
            chk("rst_carry", 32'(co16), 0);
        end
        if (hs16) begin
            chk("idle_after_hs16_in_ready", 32'(ir16), 1);
            chk("idle_after_hs16_out_valid", 32'(ov16), 0);
        end
        hs16 = 1'b0;
        if (ov16 === 1'b1) begin
            chk("result_pending16", 32'(q16.size() != 0), 1);
            if (q16.size() != 0) begin
                if (!pv16) chk("latency16", 32'(cyc - (q16[0].acc + 1)), 32);
                chk("sum16", 32'(s16), 32'(q16[0].sum));
                chk("carry16", 32'(co16), 32'(q16[0].co));
                chk("busy_in_ready16", 32'(ir16), 0);
                if (or16) begin
                    void'(q16.pop_front());
                    hs16 = 1'b1;
                    n_got16++;
                end
            end
        end
        pv16 = (ov16 === 1'b1);

        if (hs1) chk("idle_after_hs1_in_ready", 32'(ir1), 1);
        hs1 = 1'b0;
        if (ov1 === 1'b1) begin
            chk("result_pending1", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                if (!pv1) chk("latency1", 32'(cyc - (q1[0].acc + 1)), 2);
                chk("sum1", 32'(s1), 32'(q1[0].sum[0]));
                chk("carry1", 32'(co1), 32'(q1[0].co));
                if (or1) begin
                    void'(q1.pop_front());
                    hs1 = 1'b1;
                    n_got1++;
                end
            end
        end
        pv1 = (ov1 === 1'b1);

        if (done_req && !done_ack) begin
            chk("no_timeouts", 32'(tmo), 0);
            chk("queue16_drained", 32'(q16.size()), 0);
            chk("queue1_drained", 32'(q1.size()), 0);
            chk("result_count16", 32'(n_got16), 32'(n_push16));
            chk("result_count1", 32'(n_got1), 32'(n_push1));
            done_ack = 1'b1;
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send16(input logic [15:0] av, input logic [15:0] bv);
        int          t = 0;
        logic [16:0] r;
        exp_t        e;
        while (!ir16 && t < 500) begin
            tick(1);
            t++;
        end
        if (!ir16) begin
            tmo++;
            return;
        end
        iv16 = 1'b1;
        a16 = av;
        b16 = bv;
        r = {1'b0, av} + {1'b0, bv};
        e.sum = r[15:0];
        e.co = r[16];
        e.acc = cyc;
        q16.push_back(e);
        n_push16++;
        tick(1);
        iv16 = 1'b0;
    endtask

    task automatic send1(input logic av, input logic bv);
        int         t = 0;
        logic [1:0] r;
        exp_t       e;
        while (!ir1 && t < 50) begin
            tick(1);
            t++;
        end
        if (!ir1) begin
            tmo++;
            return;
        end
        iv1 = 1'b1;
        a1 = av;
        b1 = bv;
        r = {1'b0, av} + {1'b0, bv};
        e.sum = {15'd0, r[0]};
        e.co = r[1];
        e.acc = cyc;
        q1.push_back(e);
        n_push1++;
        tick(1);
        iv1 = 1'b0;
    endtask

    task automatic drain16();
        int t = 0;
        while (q16.size() != 0 && t < 2000) begin
            tick(1);
            t++;
        end
        if (q16.size() != 0) tmo++;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tick(1);
        chk_rst = 1'b1;
        tick(1);
        chk_rst = 1'b0;
        rst_n = 1'b1;
        tick(1);

        send16(16'h0003, 16'h0005);
        drain16();
        send16(16'hFFFF, 16'h0001);
        send16(16'hFFFF, 16'hFFFF);
        drain16();

        // Backpressure: hold the result for 10 cycles in DONE.
        or16 = 1'b0;
        send16(16'h00F0, 16'h0F0F);
        t = 0;
        while (!ov16 && t < 100) begin
            tick(1);
            t++;
        end
        if (!ov16) tmo++;
        tick(10);
        or16 = 1'b1;
        drain16();

        // Operands presented mid-add must be ignored.
        send16(16'h1234, 16'h1111);
        tick(5);
        iv16 = 1'b1;
        a16 = 16'hAAAA;
        b16 = 16'h5555;
        tick(1);
        iv16 = 1'b0;
        drain16();

        // Reset lands on the 7th edge of an add; the pending result is discarded.
        send16(16'h1111, 16'h2222);
        tick(5);
        rst_n = 1'b0;
        n_push16 -= q16.size();
        q16.delete();
        tick(1);
        chk_rst = 1'b1;
        rst_n = 1'b1;
        tick(1);
        chk_rst = 1'b0;
        send16(16'h0002, 16'h0002);
        drain16();

        fork
            begin
                repeat (20) send16(16'($urandom), 16'($urandom));
                drain16();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    or16 = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        or16 = 1'b1;
        repeat (6) send16(16'($urandom), 16'($urandom));
        drain16();

        or1 = 1'b1;
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b1);
        send1(1'b1, 1'b0);
        send1(1'b1, 1'b1);
        tick(6);

        done_req = 1'b1;
        t = 0;
        while (!done_ack && t < 10) begin
            tick(1);
            t++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
